register_file: RTL and testbench

General-purpose register file for the single-cycle RISC datapath, sitting directly downstream of the write-back select mux. It accepts the selected 32-bit write-back word (memory load data or ALU result) and commits it to the addressed register on the clock edge. It serves two combinational read ports to the decode/ALU operand stage. Register 0 is hardwired to zero.

---
 rtl/risc_pkg.sv | 18 +
 rtl/register_file_if.sv | 31 +++
 rtl/regfile_read_port.sv | 51 +++++
 rtl/register_file.sv | 69 ++++++
 tb/tb_register_file.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// risc_pkg: shared sizing and helper types for the single-cycle RISC datapath.
// Holds register file geometry, the hardwired zero-register index and the
// width/limit of the committed-write counter.
package risc_pkg;

  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;
  localparam int ADDR_W     = $clog2(NUM_REGS);
  localparam int WR_COUNT_W = 16;

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [ADDR_W-1:0]     reg_addr_t;
  typedef logic [WR_COUNT_W-1:0] wr_count_t;

  localparam reg_addr_t ZERO_REG     = '0;
  localparam wr_count_t WR_COUNT_MAX = '1;

endpackage

// File: rtl/register_file_if.sv
// register_file_if: bundles the read/write buses of the register file.
//   rd_addr_a/b : read addresses (rs/rt) from the decode stage
//   rd_data_a/b : combinational read data back to the operand stage
//   wr_en       : RegWrite from control
//   wr_addr     : destination register after RegDst select
//   wr_data     : write-back word from the write-back select mux
//   wr_count    : saturating count of committed writes since reset
// master = datapath side, slave = register file side.
interface register_file_if;
  import risc_pkg::*;

  reg_addr_t rd_addr_a;
  reg_addr_t rd_addr_b;
  word_t     rd_data_a;
  word_t     rd_data_b;
  logic      wr_en;
  reg_addr_t wr_addr;
  word_t     wr_data;
  wr_count_t wr_count;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
    input  rd_data_a, rd_data_b, wr_count
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
    output rd_data_a, rd_data_b, wr_count
  );

endinterface

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port of the register file.
// Selects a register from the storage array, forces register 0 to read zero
// and, when WB_BYPASS_EN is defined, forwards the in-flight write-back word
// to the port when it targets the same register (write-first).
// Ports:
//   rst_n   : active-low reset, blocks forwarding while low
//   rd_addr : read address
//   regs    : storage array, registers 1..NUM_REGS-1
//   wr_en   : write enable of the write port
//   wr_addr : write address of the write port
//   wr_data : write data of the write port
//   rd_data : read data
// Build option: WB_BYPASS_EN (undefined = read-first).
module regfile_read_port
  import risc_pkg::*;
(
  input  logic                             rst_n,
  input  reg_addr_t                        rd_addr,
  input  logic [NUM_REGS-1:1][DATA_W-1:0]  regs,
  input  logic                             wr_en,
  input  reg_addr_t                        wr_addr,
  input  word_t                            wr_data,
  output word_t                            rd_data
);

  word_t stored;

  // NUM_REGS:1 select; register 0 has no storage so it falls to the zero default.
  always_comb begin
    stored = '0;
    if (rd_addr != ZERO_REG) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (rd_addr == reg_addr_t'(i)) stored = regs[i];
      end
    end
  end

`ifdef WB_BYPASS_EN
  logic bypass_hit;

  // Forward only a write that will actually commit at the coming edge.
  assign bypass_hit = rst_n && wr_en && (wr_addr != ZERO_REG) && (wr_addr == rd_addr);
  assign rd_data    = bypass_hit ? wr_data : stored;
`else
  logic unused_bypass;

  assign unused_bypass = ^{rst_n, wr_en, wr_addr, wr_data};
  assign rd_data       = stored;
`endif

endmodule

// File: rtl/register_file.sv
// register_file: general-purpose register file of the single-cycle RISC
// datapath. One synchronous write port fed by the write-back select mux and
// two combinational read ports for the operand stage. Register 0 reads zero
// and ignores writes.
// Ports:
//   clk   : single clock, writes commit on its rising edge
//   rst_n : asynchronous active-low reset, clears all registers and wr_count
//   bus   : register_file_if slave modport (read/write buses, wr_count)
// Build option: WB_BYPASS_EN selects write-first reads (see regfile_read_port).
module register_file
  import risc_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  register_file_if.slave bus
);

  logic [NUM_REGS-1:1][DATA_W-1:0] regs;
  wr_count_t                       wr_count_q;
  logic                            wr_commit;

  function automatic wr_count_t sat_inc(input wr_count_t v);
    return (v == WR_COUNT_MAX) ? v : v + wr_count_t'(1);
  endfunction

  // A write to the zero register is dropped entirely, including the count.
  assign wr_commit = bus.wr_en && (bus.wr_addr != ZERO_REG);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (wr_commit) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (bus.wr_addr == reg_addr_t'(i)) regs[i] <= bus.wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count_q <= '0;
    end else if (wr_commit) begin
      wr_count_q <= sat_inc(wr_count_q);
    end
  end

  assign bus.wr_count = wr_count_q;

  regfile_read_port u_port_a (
    .rst_n   (rst_n),
    .rd_addr (bus.rd_addr_a),
    .regs    (regs),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_data (bus.rd_data_a)
  );

  regfile_read_port u_port_b (
    .rst_n   (rst_n),
    .rd_addr (bus.rd_addr_b),
    .regs    (regs),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_data (bus.rd_data_b)
  );

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed self-checking bench for register_file.
module tb_register_file;
  import risc_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  register_file_if bus ();

  register_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [31:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = reg_addr_t'(addr);
    bus.wr_data = data;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Reset held with a write pending: nothing may land.
    rst_n         = 1'b0;
    bus.rd_addr_a = 5'd5;
    bus.rd_addr_b = 5'd0;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 5'd5;
    bus.wr_data   = 32'hDEADBEEF;
    tick();
    tick();
    chk("rst_rd_a", bus.rd_data_a, 32'h0);
    chk("rst_rd_b", bus.rd_data_b, 32'h0);
    chk("rst_count", 32'(bus.wr_count), 32'h0);
    bus.wr_en = 1'b0;
    rst_n     = 1'b1;
    tick();
    chk("post_rst_reg5", bus.rd_data_a, 32'h0);

    // Basic write then read on both ports.
    wr(7, 32'h12345678);
    bus.rd_addr_a = 5'd7;
    bus.rd_addr_b = 5'd7;
    #1;
    chk("basic_rd_a", bus.rd_data_a, 32'h12345678);
    chk("basic_rd_b", bus.rd_data_b, 32'h12345678);
    chk("basic_count", 32'(bus.wr_count), 32'd1);

    // Zero register ignores writes and does not count.
    wr(0, 32'hFFFFFFFF);
    bus.rd_addr_a = 5'd0;
    #1;
    chk("zero_rd_a", bus.rd_data_a, 32'h0);
    chk("zero_count", 32'(bus.wr_count), 32'd1);

    // Same-cycle hazard on reg 3; port B watches an unrelated register.
    wr(3, 32'h1);
    bus.rd_addr_a = 5'd3;
    bus.rd_addr_b = 5'd7;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 5'd3;
    bus.wr_data   = 32'h2;
    #1;
`ifdef WB_BYPASS_EN
    chk("hazard_before", bus.rd_data_a, 32'h2);
`else
    chk("hazard_before", bus.rd_data_a, 32'h1);
`endif
    chk("hazard_other", bus.rd_data_b, 32'h12345678);
    tick();
    bus.wr_en = 1'b0;
    #1;
    chk("hazard_after", bus.rd_data_a, 32'h2);
    chk("hazard_count", 32'(bus.wr_count), 32'd3);

    // Write-back bus at X with wr_en low must be harmless.
    bus.wr_addr = 'x;
    bus.wr_data = 'x;
    tick();
    bus.rd_addr_a = 5'd7;
    #1;
    chk("x_idle_reg7", bus.rd_data_a, 32'h12345678);
    chk("x_idle_count", 32'(bus.wr_count), 32'd3);

    // Load regs 1..31.
    for (int i = 1; i < NUM_REGS; i++) wr(i, 32'hA5000000 | 32'(i));
    bus.rd_addr_a = 5'd31;
    bus.rd_addr_b = 5'd1;
    #1;
    chk("load_reg31", bus.rd_data_a, 32'hA500001F);
    chk("load_reg1", bus.rd_data_b, 32'hA5000001);
    chk("load_count", 32'(bus.wr_count), 32'd34);

    // Async reset mid-cycle with a write pending for the next edge.
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd20;
    bus.wr_data = 32'hAAAA5555;
    #3;
    rst_n = 1'b0;
    #1;
    bus.wr_en = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      bus.rd_addr_a = reg_addr_t'(i);
      bus.rd_addr_b = reg_addr_t'(NUM_REGS - 1 - i);
      #0.1;
      chk($sformatf("async_rd_a_%0d", i), bus.rd_data_a, 32'h0);
      chk($sformatf("async_rd_b_%0d", i), bus.rd_data_b, 32'h0);
    end
    chk("async_count", 32'(bus.wr_count), 32'h0);
    tick();
    rst_n         = 1'b1;
    bus.rd_addr_a = 5'd20;
    tick();
    chk("async_drop_reg20", bus.rd_data_a, 32'h0);
    chk("async_drop_count", 32'(bus.wr_count), 32'h0);

    // Saturation: 65540 writes to reg 9.
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd9;
    for (int i = 0; i < 65540; i++) begin
      bus.wr_data = 32'(i);
      tick();
      if (i == 65533) chk("sat_fffe", 32'(bus.wr_count), 32'h0000FFFE);
      if (i == 65534) chk("sat_ffff", 32'(bus.wr_count), 32'h0000FFFF);
    end
    bus.wr_en     = 1'b0;
    bus.rd_addr_a = 5'd9;
    #1;
    chk("sat_count", 32'(bus.wr_count), 32'h0000FFFF);
    chk("sat_reg9", bus.rd_data_a, 32'h00010003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
